// File: rtl/mem_arb_pkg.sv
// Shared opcode and state encodings for the memory arbiter.
// Load/store sizes follow RISC-V funct3.
package mem_arb_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_enum;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_enum;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IF_ACC,
    ST_LS_ACC,
    ST_DONE
  } arb_state_e;

  // Unsigned forms only exist for loads; anything else is unusable.
  function automatic logic misaligned(
    input logic       wr,
    input logic [2:0] sel,
    input logic [1:0] off
  );
    logic bad;
    case (sel)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = off[0];
      MEM_W:   bad = |off;
      MEM_BU:  bad = wr;
      MEM_HU:  bad = wr | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_lsu_align.sv
// Byte-lane generation, store replication and load extraction.
// Purely combinational.
module lsu_align
  import mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      sel_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      byte_en_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    case (sel_i[1:0])
      2'b00: begin
        byte_en_o = 4'b0001 << off_i;
        wdata_o   = {(XLEN/8){wdata_i[7:0]}};
      end
      2'b01: begin
        byte_en_o = 4'b0011 << off_i;
        wdata_o   = {(XLEN/16){wdata_i[15:0]}};
      end
      default: begin
        byte_en_o = 4'b1111;
        wdata_o   = wdata_i;
      end
    endcase
    case (sel_i)
      MEM_B:   rdata_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
      MEM_H:   rdata_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
      MEM_BU:  rdata_o = {{(XLEN-8){1'b0}}, sh[7:0]};
      MEM_HU:  rdata_o = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: rdata_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates instruction fetch and load/store onto one memory port.
// Load/store wins ties; accesses time out after TIMEOUT wait cycles.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            if_ack_o,
  input  logic            ls_req_i,
  input  logic            ls_wr_en_i,
  input  logic [2:0]      ls_sel_i,
  input  logic [XLEN-1:0] ls_addr_i,
  input  logic [XLEN-1:0] ls_wdata_i,
  output logic [XLEN-1:0] ls_rdata_o,
  output logic            ls_ack_o,
  output logic            ls_err_o,
  output logic            mem_req_o,
  output logic            mem_wr_en_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_byte_en_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i,
  output logic            busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] WMASK = ~XLEN'(3);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            own_ls_q, own_ls_d;
  logic            err_q, err_d;
  logic            wr_q, wr_d;
  logic [2:0]      sel_q, sel_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_q, mem_wr_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic            idle, done, mis;
  logic [2:0]      al_sel;
  logic [1:0]      al_off;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;

  assign idle   = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign al_sel = idle ? ls_sel_i : sel_q;
  assign al_off = idle ? ls_addr_i[1:0] : off_q;
  assign mis    = misaligned(ls_wr_en_i, ls_sel_i, ls_addr_i[1:0]);

  lsu_align #(.XLEN(XLEN)) u_align (
    .sel_i     (al_sel),
    .off_i     (al_off),
    .wdata_i   (ls_wdata_i),
    .rdata_i   (mem_rdata_i),
    .byte_en_o (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      own_ls_q    <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      sel_q       <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_ls_q    <= own_ls_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      sel_q       <= sel_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // A rejected ls request spends one LS_ACC cycle with no memory
  // request so its ack lands at the same latency as a real access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ls_req_i)      state_d = ST_LS_ACC;
        else if (if_req_i) state_d = ST_IF_ACC;
      end
      ST_IF_ACC, ST_LS_ACC: begin
        if (err_q || mem_ack_i || cnt_q == CNT_LAST) state_d = ST_DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    own_ls_d    = own_ls_q;
    err_d       = err_q;
    wr_d        = wr_q;
    sel_d       = sel_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        err_d       = 1'b0;
        rdata_d     = '0;
        mem_req_d   = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = '0;
        mem_wdata_d = '0;
        if (ls_req_i) begin
          own_ls_d = 1'b1;
          err_d    = mis;
          wr_d     = ls_wr_en_i;
          sel_d    = ls_sel_i;
          off_d    = ls_addr_i[1:0];
          if (!mis) begin
            mem_req_d  = 1'b1;
            mem_wr_d   = ls_wr_en_i;
            mem_addr_d = ls_addr_i & WMASK;
            if (ls_wr_en_i) begin
              mem_be_d    = al_be;
              mem_wdata_d = al_wdata;
            end
          end
        end else if (if_req_i) begin
          own_ls_d   = 1'b0;
          wr_d       = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = if_addr_i & WMASK;
        end
      end
      ST_IF_ACC, ST_LS_ACC: begin
        if (!err_q) begin
          if (mem_ack_i)
            rdata_d = !own_ls_q ? mem_rdata_i :
                      wr_q ? '0 : al_rdata;
          else if (cnt_q == CNT_LAST)
            err_d = 1'b1;
        end
        if (state_d == ST_DONE) begin
          mem_req_d   = 1'b0;
          mem_wr_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy_o        = !idle;
  assign if_ack_o      = done & ~own_ls_q;
  assign ls_ack_o      = done & own_ls_q;
  assign ls_err_o      = ls_ack_o & err_q;
  assign if_rdata_o    = if_ack_o ? rdata_q : '0;
  assign ls_rdata_o    = ls_ack_o ? rdata_q : '0;
  assign mem_req_o     = mem_req_q;
  assign mem_wr_en_o   = mem_wr_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_byte_en_o = mem_be_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule
